hilo_md_unit: RTL
=================

# hilo_md_unit

Multi-cycle multiply/divide unit in the EX stage. Accepts MULT/MULTU/DIV/DIVU operands and iterates for 32 cycles. It drives the 65-bit EX HILO write bus {hi, lo, we} that the HILO register consumes, with write enable pulsing for exactly one cycle per operation. It stalls the pipeline via `busy_o` while iterating, and can be flushed mid-operation.

## Interface
Parameters:
- `WIDTH`, 32: operand width. Only 32 is supported; the iteration count equals `WIDTH`.

Ports:
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `start_i`  in  1  issue request; sampled only in IDLE
- `op_i`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- `src_a_i`  in  32  multiplicand / dividend
- `src_b_i`  in  32  multiplier / divisor
- `flush_i`  in  1  synchronous abort; discards any in-flight operation
- `busy_o`  out  1  stall request to the pipeline
- `ex_hilo_bus_o`  out  65  bit [0] = HILO write enable; [64:33] = hi; [32:1] = lo

## Operation
- States: IDLE, MUL, DIV, FIX, DONE. Reset forces IDLE.
- Reset values: `ex_hilo_bus_o` = 0 and `busy_o` = 0; all internal registers are cleared.
- IDLE, `start_i`=1, `flush_i`=0:
  - latch operand magnitudes; signed ops take the two's-complement absolute value
  - latch the result sign bits
  - clear the iteration counter
  - multiply ops go to MUL; divide ops go to DIV
- Divide by zero (DIV/DIVU with `src_b_i`=0): IDLE goes directly to DONE.
  - result: hi = `src_a_i` as given, lo = 32'hFFFF_FFFF
- MUL: shift-add on magnitudes, one multiplier bit per cycle.
  - 64-bit accumulator
  - after 32 iterations, go to FIX
- DIV: restoring division on magnitudes, one quotient bit per cycle.
  - 33-bit partial remainder
  - after 32 iterations, go to FIX
- FIX (one cycle): apply signs and register the result, then go to DONE.
  - MULT: negate the 64-bit product if a[31]^b[31]
  - DIV: negate the quotient if a[31]^b[31]; negate the remainder if a[31]
  - hi = product[63:32] or remainder; lo = product[31:0] or quotient
  - unsigned ops pass through unchanged
- DONE (one cycle):
  - `ex_hilo_bus_o[0]` = 1 & ~`flush_i`
  - data bits hold the result
  - next state is IDLE unconditionally; `start_i` is ignored here, since the issuing instruction is still in EX
- Outside DONE, `ex_hilo_bus_o[0]` = 0. Data bits hold their last value and are don't-care.
- `busy_o` (combinational) = (IDLE & `start_i`) | MUL | DIV | FIX. It is low in DONE, so the instruction advances together with the write.
- `flush_i` has priority over `start_i`:
  - in any state, the next state is IDLE with no write
  - in IDLE, a concurrent `start_i` is dropped
  - `busy_o` still follows its equation in the flush cycle
- `start_i` in MUL/DIV/FIX is ignored; operands are not re-sampled.
- Overflow case DIV 0x8000_0000 / 0xFFFF_FFFF:
  - lo = 0x8000_0000, hi = 0; no exception
- Operand inputs may change freely after the accept edge.

## Timing
- Accept edge E0 is the IDLE edge with `start_i`=1.
- Iteration edges are E1..E32; FIX is registered at E33.
- The write-enable pulse falls in the cycle between E33 and E34; the state returns to IDLE at E34.
- Total: 34 cycles with `busy_o`=1, starting with the issue cycle, followed by 1 DONE cycle.
- Divide by zero: E0 goes to DONE, and the write is valid in the cycle after E0. `busy_o` is high only in the issue cycle.
- A new `start_i` is accepted at the earliest at E34, i.e. the cycle after DONE.
- Asynchronous reset is effective immediately in any state. `busy_o` and the bus go to 0 without waiting for a clock edge.

## Test plan
- MULTU 0xFFFF_FFFF × 0xFFFF_FFFF -> single-cycle write with hi=0xFFFF_FFFE, lo=0x0000_0001, exactly 34 cycles after the issue cycle; `busy_o` high for 34 cycles.
- MULT 0xFFFF_FFFD (-3) × 7 -> hi=0xFFFF_FFFF, lo=0xFFFF_FFEB. MULT 0x8000_0000 × 0x8000_0000 -> hi=0x4000_0000, lo=0.
- Division results:
  - DIV 0xFFFF_FFF9 (-7) / 2 -> lo=0xFFFF_FFFD, hi=0xFFFF_FFFF
  - DIVU 100 / 7 -> lo=0x0000_000E, hi=0x0000_0002
  - DIV 0x8000_0000 / 0xFFFF_FFFF -> lo=0x8000_0000, hi=0
- DIVU 0x1234 / 0 -> write in the cycle after issue with hi=0x0000_1234, lo=0xFFFF_FFFF; `busy_o` high for 1 cycle.
- `flush_i` pulse at iteration 10 of a DIV -> no write enable ever asserted, `busy_o`=0 the next cycle. A following MULTU 3×5 completes with lo=15, hi=0.
- `start_i` held high through DONE -> exactly one write, no second operation.
- `rst` low mid-MUL (asynchronous, between edges) -> `busy_o`=0 and bus=0 immediately. After release, state is IDLE and the next op runs normally.

Source files
------------

// File: rtl/hilo_md_unit.sv
// Iterative 32-cycle multiply/divide unit driving the EX-stage HILO write bus.
// Shift-add multiply and restoring divide on magnitudes; signs are applied in a single fix-up cycle.
module hilo_md_unit #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [1:0]           op_i,
  input  logic [WIDTH-1:0]     src_a_i,
  input  logic [WIDTH-1:0]     src_b_i,
  input  logic                 flush_i,
  output logic                 busy_o,
  output logic [2*WIDTH:0]     ex_hilo_bus_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  state_t                  state_q;
  logic [CW-1:0]           cnt_q;
  logic [2*WIDTH-1:0]      acc_q;
  logic [WIDTH-1:0]        mag_q;
  logic [WIDTH-1:0]        rem_q;
  logic                    neg_res_q;
  logic                    neg_rem_q;
  logic                    is_div_q;
  logic [WIDTH-1:0]        hi_q;
  logic [WIDTH-1:0]        lo_q;

  logic                    op_signed;
  logic [WIDTH-1:0]        abs_a;
  logic [WIDTH-1:0]        abs_b;
  logic [WIDTH:0]          mul_sum;
  logic [2*WIDTH-1:0]      mul_acc_d;
  logic [WIDTH:0]          div_shift;
  logic                    div_ge;
  logic [WIDTH-1:0]        div_rem_d;
  logic [2*WIDTH-1:0]      prod_fix;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x, input logic neg);
    return neg ? -x : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg_wide(input logic [2*WIDTH-1:0] x, input logic neg);
    return neg ? -x : x;
  endfunction

  always_comb begin
    op_signed = ~op_i[0];
    abs_a     = cond_neg(src_a_i, op_signed & src_a_i[WIDTH-1]);
    abs_b     = cond_neg(src_b_i, op_signed & src_b_i[WIDTH-1]);

    // Multiplier sits in the low half of the accumulator and is consumed LSB first.
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_q} : '0);
    mul_acc_d = {mul_sum, acc_q[WIDTH-1:1]};

    // Dividend shifts out of acc_q's low half while quotient bits shift in.
    div_shift = {rem_q, acc_q[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, mag_q};
    div_rem_d = div_ge ? WIDTH'(div_shift - {1'b0, mag_q}) : div_shift[WIDTH-1:0];

    prod_fix  = cond_neg_wide(acc_q, neg_res_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      mag_q     <= '0;
      rem_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_div_q  <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else if (flush_i) begin
      state_q <= S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            cnt_q     <= '0;
            rem_q     <= '0;
            is_div_q  <= op_i[1];
            neg_res_q <= op_signed & (src_a_i[WIDTH-1] ^ src_b_i[WIDTH-1]);
            neg_rem_q <= op_signed & src_a_i[WIDTH-1];
            acc_q     <= {{WIDTH{1'b0}}, op_i[1] ? abs_a : abs_b};
            mag_q     <= op_i[1] ? abs_b : abs_a;
            if (op_i[1] && (src_b_i == '0)) begin
              hi_q    <= src_a_i;
              lo_q    <= '1;
              state_q <= S_DONE;
            end else begin
              state_q <= op_i[1] ? S_DIV : S_MUL;
            end
          end
        end
        S_MUL: begin
          acc_q <= mul_acc_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) state_q <= S_FIX;
        end
        S_DIV: begin
          rem_q <= div_rem_d;
          acc_q <= {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], div_ge};
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) state_q <= S_FIX;
        end
        S_FIX: begin
          if (is_div_q) begin
            hi_q <= cond_neg(rem_q, neg_rem_q);
            lo_q <= cond_neg(acc_q[WIDTH-1:0], neg_res_q);
          end else begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end
          state_q <= S_DONE;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Busy drops in DONE so the issuing instruction leaves EX together with the write.
  assign busy_o = rst & (((state_q == S_IDLE) & start_i) | (state_q == S_MUL) |
                         (state_q == S_DIV) | (state_q == S_FIX));
  assign ex_hilo_bus_o = {hi_q, lo_q, (state_q == S_DONE) & ~flush_i};

endmodule
